mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/saturn_mem_pkg.sv | 33 +++
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb_grant.sv | 46 ++++
 rtl/mem_arb.sv | 189 ++++++++++++++++++
 tb/tb_mem_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/saturn_mem_pkg.sv
// Shared types and constants for the Saturn memory arbiter.
package saturn_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      RGN_ROM  = 2'd0,
      RGN_RAML = 2'd1,
      RGN_RAMH = 2'd2,
      RGN_NONE = 2'd3
   } region_e;

   localparam logic [31:0] OPEN_BUS = 32'hFFFF_FFFF;
   localparam logic [3:0]  WE_READ  = 4'hF;

   // Chip-select vector {RAMH, RAML, ROM}, active low
   function automatic logic [2:0] region_cs_n(input region_e rgn);
      logic [2:0] cs_n;
      case (rgn)
         RGN_ROM:  cs_n = 3'b110;
         RGN_RAML: cs_n = 3'b101;
         RGN_RAMH: cs_n = 3'b011;
         default:  cs_n = 3'b111;
      endcase
      return cs_n;
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side bus bundle for mem_arb; slave = arbiter view, master = requesters/memory view.
interface mem_arb_if;
   logic        P0_REQ;
   logic [24:0] P0_A;
   logic [31:0] P0_DI;
   logic [3:0]  P0_WE_N;
   logic [1:0]  P0_SEL;
   logic [31:0] P0_DO;
   logic        P0_ACK;

   logic        P1_REQ;
   logic [24:0] P1_A;
   logic [31:0] P1_DI;
   logic [3:0]  P1_WE_N;
   logic [1:0]  P1_SEL;
   logic [31:0] P1_DO;
   logic        P1_ACK;

   logic [24:0] MEM_A;
   logic [31:0] MEM_DO;
   logic [31:0] MEM_DI;
   logic [3:0]  MEM_DQM_N;
   logic        MEM_RD_N;
   logic        ROM_CS_N;
   logic        RAML_CS_N;
   logic        RAMH_CS_N;
   logic        MEM_RDY;

   modport slave (
      input  P0_REQ, P0_A, P0_DI, P0_WE_N, P0_SEL,
      input  P1_REQ, P1_A, P1_DI, P1_WE_N, P1_SEL,
      input  MEM_DI, MEM_RDY,
      output P0_DO, P0_ACK, P1_DO, P1_ACK,
      output MEM_A, MEM_DO, MEM_DQM_N, MEM_RD_N, ROM_CS_N, RAML_CS_N, RAMH_CS_N
   );

   modport master (
      output P0_REQ, P0_A, P0_DI, P0_WE_N, P0_SEL,
      output P1_REQ, P1_A, P1_DI, P1_WE_N, P1_SEL,
      output MEM_DI, MEM_RDY,
      input  P0_DO, P0_ACK, P1_DO, P1_ACK,
      input  MEM_A, MEM_DO, MEM_DQM_N, MEM_RD_N, ROM_CS_N, RAML_CS_N, RAMH_CS_N
   );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant selector for mem_arb: fixed P0 priority, or round-robin with a pointer when MEM_ARB_RR_EN is defined.
module mem_arb_grant (
`ifdef MEM_ARB_RR_EN
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       take_s,
`endif
   input  logic [1:0] req_s,
   output logic       gnt_vld_s,
   output logic       gnt_port_s
);

`ifdef MEM_ARB_RR_EN
   logic prio_r;

   // Pointer names the port that wins the next tie: the one not granted last
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prio_r <= 1'b0;
      end else if (take_s) begin
         prio_r <= ~gnt_port_s;
      end
   end

   // Round-robin tie-break, otherwise the single requester wins
   always_comb begin
      gnt_vld_s = |req_s;
      if (req_s == 2'b11) begin
         gnt_port_s = prio_r;
      end else begin
         gnt_port_s = req_s[1];
      end
   end
`else
   // Fixed priority, P0 first
   always_comb begin
      gnt_vld_s = |req_s;
      if (req_s[0]) begin
         gnt_port_s = 1'b0;
      end else begin
         gnt_port_s = req_s[1];
      end
   end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-port memory arbiter: IDLE/ISSUE/WAIT/DONE sequencer with wait timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed P0 priority).
module mem_arb
   import saturn_mem_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic     CLK,
   input  logic     RST_N,
   input  logic     CE_R,
   mem_arb_if.slave bus,
   output logic     BUSY,
   output logic     ERR
);

   localparam int            CW        = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   arb_state_e    state_r;
   logic          gnt_r;
   logic          rd_r;
   logic          busy_r;
   logic          err_r;
   logic [1:0]    ack_r;
   logic [1:0]    blk_r;
   logic [CW-1:0] wait_cnt_r;
   logic [24:0]   mem_a_r;
   logic [31:0]   mem_do_r;
   logic [3:0]    dqm_r;
   logic          rd_n_r;
   logic [2:0]    cs_n_r;
   logic [31:0]   do0_r;
   logic [31:0]   do1_r;

   logic [1:0]    req_s;
   logic          gnt_vld_s;
   logic          gnt_port_s;
   logic [24:0]   sel_a_s;
   logic [31:0]   sel_di_s;
   logic [3:0]    sel_we_s;
   logic [1:0]    sel_rgn_s;
   logic [31:0]   rd_val_s;

   // A port that was just acknowledged sits out one IDLE cycle so a lingering REQ is not re-served
   assign req_s    = {bus.P1_REQ & ~blk_r[1], bus.P0_REQ & ~blk_r[0]};
   assign rd_val_s = bus.MEM_RDY ? bus.MEM_DI : OPEN_BUS;

`ifdef MEM_ARB_RR_EN
   logic take_s;
   assign take_s = CE_R & (state_r == ST_IDLE) & gnt_vld_s;

   mem_arb_grant u_grant (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .take_s     (take_s),
      .req_s      (req_s),
      .gnt_vld_s  (gnt_vld_s),
      .gnt_port_s (gnt_port_s)
   );
`else
   mem_arb_grant u_grant (
      .req_s      (req_s),
      .gnt_vld_s  (gnt_vld_s),
      .gnt_port_s (gnt_port_s)
   );
`endif

   // Request fields of the port being granted this cycle
   always_comb begin
      sel_a_s   = bus.P0_A;
      sel_di_s  = bus.P0_DI;
      sel_we_s  = bus.P0_WE_N;
      sel_rgn_s = bus.P0_SEL;
      if (gnt_port_s) begin
         sel_a_s   = bus.P1_A;
         sel_di_s  = bus.P1_DI;
         sel_we_s  = bus.P1_WE_N;
         sel_rgn_s = bus.P1_SEL;
      end else begin
         sel_a_s   = bus.P0_A;
         sel_di_s  = bus.P0_DI;
         sel_we_s  = bus.P0_WE_N;
         sel_rgn_s = bus.P0_SEL;
      end
   end

   // Transaction sequencer; every memory-side and requester output is registered here
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         gnt_r      <= 1'b0;
         rd_r       <= 1'b0;
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
         ack_r      <= 2'b00;
         blk_r      <= 2'b00;
         wait_cnt_r <= {CW{1'b0}};
         mem_a_r    <= 25'h0;
         mem_do_r   <= 32'h0;
         dqm_r      <= 4'hF;
         rd_n_r     <= 1'b1;
         cs_n_r     <= 3'b111;
         do0_r      <= 32'h0;
         do1_r      <= 32'h0;
      end else if (CE_R) begin
         ack_r <= 2'b00;
         err_r <= 1'b0;
         blk_r <= 2'b00;
         case (state_r)
            ST_IDLE: begin
               if (gnt_vld_s) begin
                  gnt_r  <= gnt_port_s;
                  rd_r   <= (sel_we_s == WE_READ);
                  busy_r <= 1'b1;
                  if (region_e'(sel_rgn_s) == RGN_NONE) begin
                     // Unmapped region: answer with open bus, no chip select
                     state_r <= ST_DONE;
                     ack_r   <= gnt_port_s ? 2'b10 : 2'b01;
                     if (sel_we_s == WE_READ) begin
                        if (gnt_port_s) begin
                           do1_r <= OPEN_BUS;
                        end else begin
                           do0_r <= OPEN_BUS;
                        end
                     end
                  end else begin
                     state_r  <= ST_ISSUE;
                     mem_a_r  <= sel_a_s;
                     mem_do_r <= sel_di_s;
                     cs_n_r   <= region_cs_n(region_e'(sel_rgn_s));
                     rd_n_r   <= (sel_we_s != WE_READ);
                     dqm_r    <= (sel_we_s == WE_READ) ? 4'h0 : sel_we_s;
                  end
               end
            end
            ST_ISSUE: begin
               state_r    <= ST_WAIT;
               wait_cnt_r <= {CW{1'b0}};
            end
            ST_WAIT: begin
               if (bus.MEM_RDY || (wait_cnt_r == WAIT_LAST)) begin
                  state_r <= ST_DONE;
                  ack_r   <= gnt_r ? 2'b10 : 2'b01;
                  err_r   <= ~bus.MEM_RDY;
                  cs_n_r  <= 3'b111;
                  rd_n_r  <= 1'b1;
                  dqm_r   <= 4'hF;
                  if (rd_r) begin
                     if (gnt_r) begin
                        do1_r <= rd_val_s;
                     end else begin
                        do0_r <= rd_val_s;
                     end
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               blk_r   <= gnt_r ? 2'b10 : 2'b01;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               cs_n_r  <= 3'b111;
               rd_n_r  <= 1'b1;
               dqm_r   <= 4'hF;
            end
         endcase
      end
   end

   assign bus.P0_DO     = do0_r;
   assign bus.P1_DO     = do1_r;
   assign bus.P0_ACK    = ack_r[0];
   assign bus.P1_ACK    = ack_r[1];
   assign bus.MEM_A     = mem_a_r;
   assign bus.MEM_DO    = mem_do_r;
   assign bus.MEM_DQM_N = dqm_r;
   assign bus.MEM_RD_N  = rd_n_r;
   assign bus.ROM_CS_N  = cs_n_r[0];
   assign bus.RAML_CS_N = cs_n_r[1];
   assign bus.RAMH_CS_N = cs_n_r[2];
   assign BUSY          = busy_r;
   assign ERR           = err_r;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table with scoreboard plus tie, timeout and reset sequences.
module tb_mem_arb;

   localparam int MAX_W = 8;

   typedef struct {
      logic        port;
      logic [1:0]  sel;
      logic [3:0]  we;
      logic [24:0] a;
      logic [31:0] di;
      logic [31:0] mdi;
      int          rdy_lat;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] dout;
      logic        err;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N;
   logic CE_R;
   logic BUSY;
   logic ERR;

   int          n_chk  = 0;
   int          n_fail = 0;
   exp_t        sb_q[$];
   logic [31:0] do_model[2];
   vec_t        vecs[7];

   mem_arb_if bif ();

   mem_arb #(.MAX_WAIT(MAX_W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CE_R  (CE_R),
      .bus   (bif),
      .BUSY  (BUSY),
      .ERR   (ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_pop(output exp_t e);
      if (sb_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL sb_empty: got ack with no expected entry");
         e = '{1'b0, 32'h0, 1'b0};
      end else begin
         e = sb_q.pop_front();
      end
   endtask

   task automatic drive_req(input logic p, input logic r, input logic [24:0] a,
                            input logic [31:0] di, input logic [3:0] we, input logic [1:0] sel);
      if (p) begin
         bif.P1_REQ = r; bif.P1_A = a; bif.P1_DI = di; bif.P1_WE_N = we; bif.P1_SEL = sel;
      end else begin
         bif.P0_REQ = r; bif.P0_A = a; bif.P0_DI = di; bif.P0_WE_N = we; bif.P0_SEL = sel;
      end
   endtask

   function automatic logic [2:0] cs_vec();
      return ~{bif.RAMH_CS_N, bif.RAML_CS_N, bif.ROM_CS_N};
   endfunction

   // One transaction from the table: drive, watch the bus each cycle, score the ACK
   task automatic run_vec(input int idx, input vec_t v);
      logic        rd;
      logic        to;
      logic        nul;
      logic [31:0] exp_do;
      logic [2:0]  cs_seen;
      int          ack_c;
      int          cs_cnt;
      int          err_cnt;
      int          bad;
      int          exp_ack;
      exp_t        e;
      rd  = (v.we == 4'hF);
      nul = (v.sel == 2'd3);
      to  = !nul && (v.rdy_lat >= MAX_W);
      if (rd) exp_do = (to || nul) ? 32'hFFFF_FFFF : v.mdi;
      else    exp_do = do_model[v.port];
      do_model[v.port] = exp_do;
      exp_ack = nul ? 1 : (to ? 2 + MAX_W : 3 + v.rdy_lat);
      sb_q.push_back('{v.port, exp_do, to});
      drive_req(v.port, 1'b1, v.a, v.di, v.we, v.sel);
      bif.MEM_DI  = v.mdi;
      bif.MEM_RDY = (v.rdy_lat == 0);
      ack_c = 0; cs_cnt = 0; err_cnt = 0; bad = 0; cs_seen = 3'b000;
      for (int c = 1; c <= 40 && ack_c == 0; c++) begin
         @(negedge CLK);
         if (cs_vec() != 3'b000) begin
            cs_cnt++;
            cs_seen = cs_seen | cs_vec();
            if (bif.MEM_DQM_N !== (rd ? 4'h0 : v.we)) bad++;
            if (bif.MEM_RD_N !== !rd) bad++;
            if (bif.MEM_A !== v.a) bad++;
            if (bif.MEM_DO !== v.di) bad++;
         end
         if (ERR) err_cnt++;
         if ((v.port ? bif.P0_ACK : bif.P1_ACK) !== 1'b0) bad++;
         if ((v.port ? bif.P1_ACK : bif.P0_ACK) === 1'b1) begin
            ack_c = c;
            sb_pop(e);
            chk($sformatf("v%0d_port", idx), {31'h0, v.port}, {31'h0, e.port});
            chk($sformatf("v%0d_do", idx), v.port ? bif.P1_DO : bif.P0_DO, e.dout);
            chk($sformatf("v%0d_err", idx), err_cnt, {31'h0, e.err});
            drive_req(v.port, 1'b0, v.a, v.di, v.we, v.sel);
         end else if (c == 2 + v.rdy_lat) begin
            bif.MEM_RDY = 1'b1;
         end
      end
      chk($sformatf("v%0d_ack_cycle", idx), ack_c, exp_ack);
      chk($sformatf("v%0d_cs_cycles", idx), cs_cnt, nul ? 0 : exp_ack - 1);
      chk($sformatf("v%0d_cs_line", idx), {29'h0, cs_seen}, nul ? 32'h0 : (32'h1 << v.sel));
      chk($sformatf("v%0d_bus", idx), bad, 0);
      bif.MEM_RDY = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_idle_busy", idx), {31'h0, BUSY}, 32'h0);
      chk($sformatf("v%0d_idle_rdn", idx), {31'h0, bif.MEM_RD_N}, 32'h1);
      chk($sformatf("v%0d_idle_dqm", idx), {28'h0, bif.MEM_DQM_N}, 32'hF);
      chk($sformatf("v%0d_other_do", idx), v.port ? bif.P0_DO : bif.P1_DO, do_model[~v.port]);
      @(negedge CLK);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cs"}, {29'h0, cs_vec()}, 32'h0);
      chk({tag, "_rdn"}, {31'h0, bif.MEM_RD_N}, 32'h1);
      chk({tag, "_dqm"}, {28'h0, bif.MEM_DQM_N}, 32'hF);
      chk({tag, "_busy"}, {31'h0, BUSY}, 32'h0);
      chk({tag, "_err"}, {31'h0, ERR}, 32'h0);
      chk({tag, "_ack"}, {30'h0, bif.P1_ACK, bif.P0_ACK}, 32'h0);
      chk({tag, "_do0"}, bif.P0_DO, 32'h0);
      chk({tag, "_do1"}, bif.P1_DO, 32'h0);
      chk({tag, "_mema"}, {7'h0, bif.MEM_A}, 32'h0);
      chk({tag, "_memdo"}, bif.MEM_DO, 32'h0);
   endtask

   initial begin
      exp_t e;
      int   nack;
      int   stray;
      vecs[0] = '{1'b0, 2'd1, 4'hF,    25'h0000100, 32'h0000_0000, 32'h1234_5678, 0};
      vecs[1] = '{1'b1, 2'd2, 4'b1100, 25'h0ABCDEF, 32'hCAFE_BABE, 32'h5555_5555, 5};
      vecs[2] = '{1'b0, 2'd0, 4'hF,    25'h1000004, 32'h0000_0000, 32'h7777_7777, 99};
      vecs[3] = '{1'b1, 2'd1, 4'hF,    25'h0000040, 32'h0000_0000, 32'hA5A5_0001, 0};
      vecs[4] = '{1'b1, 2'd3, 4'hF,    25'h1FFFFFF, 32'h0000_0000, 32'h2222_2222, 0};
      vecs[5] = '{1'b0, 2'd0, 4'b0000, 25'h0000008, 32'hDEAD_BEEF, 32'h3333_3333, 2};
      vecs[6] = '{1'b0, 2'd2, 4'hF,    25'h0123456, 32'h0000_0000, 32'h0BAD_F00D, MAX_W - 1};
      do_model[0] = 32'h0;
      do_model[1] = 32'h0;

      RST_N = 1'b0;
      CE_R  = 1'b0;
      drive_req(1'b0, 1'b0, 25'h0, 32'h0, 4'hF, 2'd0);
      drive_req(1'b1, 1'b0, 25'h0, 32'h0, 4'hF, 2'd0);
      bif.MEM_DI  = 32'h0;
      bif.MEM_RDY = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_state("rst");
      CE_R = 1'b1;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Both ports tie and re-request at once after every ACK
      drive_req(1'b0, 1'b1, 25'h0000200, 32'h0, 4'hF, 2'd1);
      drive_req(1'b1, 1'b1, 25'h0000300, 32'h0, 4'hF, 2'd1);
      bif.MEM_RDY = 1'b1;
      bif.MEM_DI  = 32'h1000_0000;
      for (int k = 0; k < 4; k++) sb_q.push_back('{k[0], 32'h1000_0000 + k, 1'b0});
      nack = 0;
      for (int c = 0; c < 60 && nack < 4; c++) begin
         @(negedge CLK);
         if (bif.P0_ACK || bif.P1_ACK) begin
            sb_pop(e);
            chk($sformatf("tie%0d_port", nack), {31'h0, bif.P1_ACK}, {31'h0, e.port});
            chk($sformatf("tie%0d_do", nack), bif.P1_ACK ? bif.P1_DO : bif.P0_DO, e.dout);
            nack++;
            bif.MEM_DI = 32'h1000_0000 + nack;
            if (nack == 4) begin
               bif.P0_REQ = 1'b0;
               bif.P1_REQ = 1'b0;
            end
         end
      end
      chk("tie_ack_count", nack, 4);
      bif.MEM_RDY = 1'b0;
      repeat (2) @(negedge CLK);
      chk("tie_idle_busy", {31'h0, BUSY}, 32'h0);

      // Reset while the arbiter waits on a stalled memory
      drive_req(1'b0, 1'b1, 25'h0000444, 32'h0, 4'hF, 2'd0);
      stray = 0;
      repeat (3) @(negedge CLK);
      chk("midrst_cs_before", {31'h0, bif.ROM_CS_N}, 32'h0);
      RST_N = 1'b0;
      #1;
      chk_reset_state("midrst");
      bif.P0_REQ = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (bif.P0_ACK || bif.P1_ACK || BUSY) stray++;
      end
      RST_N = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         if (bif.P0_ACK || bif.P1_ACK || BUSY) stray++;
      end
      chk("midrst_no_ack", stray, 0);
      do_model[0] = 32'h0;
      do_model[1] = 32'h0;
      run_vec(7, '{1'b0, 2'd1, 4'hF, 25'h0000888, 32'h0, 32'h600D_CAFE, 1});

      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
